// File: rtl/butterfly_pkg.sv
// Shared types for the ButterFly load/store unit.
package butterfly_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } lsu_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } lsu_state_e;

    // Wide enough for the largest legal MAX_WAIT (65535).
    localparam int unsigned WAIT_W = 16;

endpackage

// File: rtl/butterfly_lsu_align.sv
// Combinational store data/strobe formatting and load extraction/extension.
module butterfly_lsu_align
    import butterfly_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_size)
            SIZE_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            SIZE_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << {st_off[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        ld_data = shifted;
        case (ld_size)
            SIZE_B: ld_data = ld_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H: ld_data = ld_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/butterfly_lsu.sv
// MEM-stage load/store unit: bus handshake with timeout, stall, registered MEM/WB result.
module butterfly_lsu
    import butterfly_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ex_valid_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_mem_write_i,
    input  logic [1:0]  ex_size_i,
    input  logic        ex_unsigned_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_we_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        dmem_valid_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ready_i
);

    lsu_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              uns_q, uns_d;
    logic [4:0]        rd_q, rd_d;
    logic              rwe_q, rwe_d;

    logic        wb_valid_d, wb_we_d, misaligned_d, bus_err_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;
    logic        dmem_valid_d, dmem_we_d;
    logic [31:0] dmem_addr_d, dmem_wdata_d;
    logic [3:0]  dmem_wstrb_d;

    logic        is_mem, misaligned;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    butterfly_lsu_align u_align (
        .st_size     (ex_size_i),
        .st_off      (ex_addr_i[1:0]),
        .st_data     (ex_wdata_i),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .rdata       (dmem_rdata_i),
        .ld_data     (ld_data)
    );

    assign is_mem  = ex_mem_read_i || ex_mem_write_i;
    assign stall_o = (state_q == BUS);

    always_comb begin
        case (ex_size_i)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = ex_addr_i[0];
            SIZE_W:  misaligned = |ex_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        rwe_d        = rwe_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_o;
        wb_data_d    = wb_data_o;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        dmem_valid_d = dmem_valid_o;
        dmem_we_d    = dmem_we_o;
        dmem_addr_d  = dmem_addr_o;
        dmem_wdata_d = dmem_wdata_o;
        dmem_wstrb_d = dmem_wstrb_o;

        unique case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_addr_i;
                        wb_rd_d    = ex_rd_i;
                        wb_we_d    = ex_reg_we_i && (ex_rd_i != 5'd0);
                    end else if (misaligned) begin
                        wb_valid_d   = 1'b1;
                        misaligned_d = 1'b1;
                        wb_rd_d      = ex_rd_i;
                        wb_data_d    = 32'd0;
                    end else begin
                        state_d      = BUS;
                        wait_d       = '0;
                        size_d       = ex_size_i;
                        off_d        = ex_addr_i[1:0];
                        uns_d        = ex_unsigned_i;
                        rd_d         = ex_rd_i;
                        rwe_d        = ex_reg_we_i;
                        dmem_valid_d = 1'b1;
                        dmem_we_d    = ex_mem_write_i;
                        dmem_addr_d  = {ex_addr_i[31:2], 2'b00};
                        dmem_wdata_d = st_wdata;
                        dmem_wstrb_d = ex_mem_write_i ? st_wstrb : 4'b0000;
                    end
                end
            end
            BUS: begin
                // Ready on the last allowed cycle still completes normally.
                if (dmem_ready_i) begin
                    state_d      = IDLE;
                    dmem_valid_d = 1'b0;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = rd_q;
                    if (dmem_we_o) begin
                        wb_data_d = 32'd0;
                    end else begin
                        wb_we_d   = rwe_q && (rd_q != 5'd0);
                        wb_data_d = ld_data;
                    end
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    state_d      = IDLE;
                    dmem_valid_d = 1'b0;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = rd_q;
                    wb_data_d    = 32'd0;
                    bus_err_d    = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            rd_q         <= 5'd0;
            rwe_q        <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_rd_o      <= 5'd0;
            wb_data_o    <= 32'd0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            dmem_valid_o <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_wdata_o <= 32'd0;
            dmem_wstrb_o <= 4'b0000;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            rwe_q        <= rwe_d;
            wb_valid_o   <= wb_valid_d;
            wb_we_o      <= wb_we_d;
            wb_rd_o      <= wb_rd_d;
            wb_data_o    <= wb_data_d;
            misaligned_o <= misaligned_d;
            bus_err_o    <= bus_err_d;
            dmem_valid_o <= dmem_valid_d;
            dmem_we_o    <= dmem_we_d;
            dmem_addr_o  <= dmem_addr_d;
            dmem_wdata_o <= dmem_wdata_d;
            dmem_wstrb_o <= dmem_wstrb_d;
        end
    end

endmodule
